// File: rtl/gba_line_window_cache_pkg.sv
// rtl/gba_line_window_cache_pkg.sv - shared constants and pixel type for the GBA line window cache
package gba_line_window_cache_pkg;

    localparam int GBA_LINE_PX      = 240;
    localparam int GBA_FRAME_LINES  = 160;
    localparam int CACHE_RING_LINES = 4;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb24_t;

endpackage

// File: rtl/gba_line_window_cache_if.sv
// rtl/gba_line_window_cache_if.sv - capture, reader pacing and neighbourhood signals of the line cache
interface gba_line_window_cache_if;

    logic       pxlValidIn;
    logic [7:0] redIn, greenIn, blueIn;
    logic       newFrameIn;
    logic       nextLine;
    logic       cacheUpdate;
    logic [7:0] curPxl;
    logic       sameLine;
    logic       newFrameOut;
    logic       overrun;

    logic [7:0] prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut;
    logic [7:0] prevLineCurPxlRedOut,  prevLineCurPxlGreenOut,  prevLineCurPxlBlueOut;
    logic [7:0] prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut;
    logic [7:0] curLinePrevPxlRedOut,  curLinePrevPxlGreenOut,  curLinePrevPxlBlueOut;
    logic [7:0] curLineCurPxlRedOut,   curLineCurPxlGreenOut,   curLineCurPxlBlueOut;
    logic [7:0] curLineNextPxlRedOut,  curLineNextPxlGreenOut,  curLineNextPxlBlueOut;
    logic [7:0] nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut;
    logic [7:0] nextLineCurPxlRedOut,  nextLineCurPxlGreenOut,  nextLineCurPxlBlueOut;
    logic [7:0] nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut;

    modport master (
        output pxlValidIn, redIn, greenIn, blueIn, newFrameIn, nextLine, cacheUpdate, curPxl,
        input  sameLine, newFrameOut, overrun,
        input  prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut,
        input  prevLineCurPxlRedOut,  prevLineCurPxlGreenOut,  prevLineCurPxlBlueOut,
        input  prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut,
        input  curLinePrevPxlRedOut,  curLinePrevPxlGreenOut,  curLinePrevPxlBlueOut,
        input  curLineCurPxlRedOut,   curLineCurPxlGreenOut,   curLineCurPxlBlueOut,
        input  curLineNextPxlRedOut,  curLineNextPxlGreenOut,  curLineNextPxlBlueOut,
        input  nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut,
        input  nextLineCurPxlRedOut,  nextLineCurPxlGreenOut,  nextLineCurPxlBlueOut,
        input  nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut
    );

    modport slave (
        input  pxlValidIn, redIn, greenIn, blueIn, newFrameIn, nextLine, cacheUpdate, curPxl,
        output sameLine, newFrameOut, overrun,
        output prevLinePrevPxlRedOut, prevLinePrevPxlGreenOut, prevLinePrevPxlBlueOut,
        output prevLineCurPxlRedOut,  prevLineCurPxlGreenOut,  prevLineCurPxlBlueOut,
        output prevLineNextPxlRedOut, prevLineNextPxlGreenOut, prevLineNextPxlBlueOut,
        output curLinePrevPxlRedOut,  curLinePrevPxlGreenOut,  curLinePrevPxlBlueOut,
        output curLineCurPxlRedOut,   curLineCurPxlGreenOut,   curLineCurPxlBlueOut,
        output curLineNextPxlRedOut,  curLineNextPxlGreenOut,  curLineNextPxlBlueOut,
        output nextLinePrevPxlRedOut, nextLinePrevPxlGreenOut, nextLinePrevPxlBlueOut,
        output nextLineCurPxlRedOut,  nextLineCurPxlGreenOut,  nextLineCurPxlBlueOut,
        output nextLineNextPxlRedOut, nextLineNextPxlGreenOut, nextLineNextPxlBlueOut
    );

endinterface

// File: rtl/gba_line_window_cache_line_ram.sv
// rtl/gba_line_window_cache_line_ram.sv - one GBA line buffer: sync write, three async reads
module gba_line_ram
    import gba_line_window_cache_pkg::*;
#(
    parameter int DEPTH = GBA_LINE_PX
) (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  rgb24_t     wdata,
    input  logic [7:0] raddr0,
    input  logic [7:0] raddr1,
    input  logic [7:0] raddr2,
    output rgb24_t     rdata0,
    output rgb24_t     rdata1,
    output rgb24_t     rdata2
);

    rgb24_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/gba_line_window_cache.sv
// rtl/gba_line_window_cache.sv - 4-line ring of captured GBA lines serving a clamped, paced 3x3 window
module gba_line_window_cache
    import gba_line_window_cache_pkg::*;
#(
    parameter int LINE_PX     = GBA_LINE_PX,
    parameter int FRAME_LINES = GBA_FRAME_LINES,
    parameter int RING_LINES  = CACHE_RING_LINES
) (
    input  logic                    pxlClk,
    input  logic                    rst,
    gba_line_window_cache_if.slave  bus
);

    localparam logic [7:0] LAST_PX   = 8'(LINE_PX - 1);
    localparam logic [7:0] LAST_LINE = 8'(FRAME_LINES - 1);
    localparam logic [7:0] FRAME_CNT = 8'(FRAME_LINES);
    localparam logic [7:0] NEAR_END  = 8'(FRAME_LINES - 3);

    logic       newFrame_prev_q;
    logic [7:0] wPxl_q, wPxl_d;
    logic [7:0] wLine_q, wLine_d;
    logic [7:0] linesDone_q, linesDone_d;
    logic [7:0] rLine_q, rLine_d;
    logic [1:0] bufPrev_q, bufPrev_d;
    logic [1:0] bufCur_q, bufCur_d;
    logic [1:0] bufNext_q, bufNext_d;
    logic       sameLine_q, newFrameOut_q;
    logic       overrun_q, overrun_d;
    rgb24_t     nb_q [3][3];
    rgb24_t     nb_d [3][3];

    logic       resync, we, same_now, advance;
    logic [1:0] wbuf;
    logic [7:0] waddr, need_lines, clamp_px, prev_line, next_line;
    rgb24_t     wdata;
    logic [7:0] col [3];
    logic [1:0] sel [3];
    rgb24_t     rd  [RING_LINES][3];

    assign resync = bus.newFrameIn & ~newFrame_prev_q;
    assign we     = bus.pxlValidIn;
    assign wbuf   = resync ? 2'd0 : wLine_q[1:0];
    assign waddr  = resync ? 8'd0 : wPxl_q;
    assign wdata  = '{red: bus.redIn, green: bus.greenIn, blue: bus.blueIn};

    // Advancing to r+1 needs r+1 and r+2 complete; near the bottom only the frame end matters.
    assign need_lines = (rLine_q >= NEAR_END) ? FRAME_CNT : rLine_q + 8'd3;
    assign same_now   = linesDone_q < need_lines;
    assign advance    = bus.nextLine & ~sameLine_q & ~same_now & (rLine_q != LAST_LINE);

    always_comb begin
        wPxl_d      = wPxl_q;
        wLine_d     = wLine_q;
        linesDone_d = linesDone_q;
        rLine_d     = rLine_q;
        overrun_d   = overrun_q;
        if (resync) begin
            wPxl_d      = we ? 8'd1 : 8'd0;
            wLine_d     = 8'd0;
            linesDone_d = 8'd0;
            rLine_d     = 8'd0;
            overrun_d   = 1'b0;
        end else begin
            if (advance) begin
                rLine_d = rLine_q + 8'd1;
            end
            if (we) begin
                if (wPxl_q == LAST_PX) begin
                    wPxl_d  = 8'd0;
                    wLine_d = wLine_q + 8'd1;
                    if (linesDone_q != FRAME_CNT) begin
                        linesDone_d = linesDone_q + 8'd1;
                    end
                end else begin
                    wPxl_d = wPxl_q + 8'd1;
                end
                // The buffer behind the reader's line still backs its prev row.
                if (rLine_q != 8'd0 && wbuf == 2'(rLine_q - 8'd1)) begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        prev_line = (rLine_d == 8'd0) ? 8'd0 : rLine_d - 8'd1;
        next_line = (rLine_d == LAST_LINE) ? LAST_LINE : rLine_d + 8'd1;
        bufPrev_d = bufPrev_q;
        bufCur_d  = bufCur_q;
        bufNext_d = bufNext_q;
        if (bus.cacheUpdate) begin
            bufPrev_d = prev_line[1:0];
            bufCur_d  = rLine_d[1:0];
            bufNext_d = next_line[1:0];
        end
    end

    always_comb begin
        clamp_px = (bus.curPxl > LAST_PX) ? LAST_PX : bus.curPxl;
        col[0]   = (clamp_px == 8'd0) ? 8'd0 : clamp_px - 8'd1;
        col[1]   = clamp_px;
        col[2]   = (clamp_px == LAST_PX) ? LAST_PX : clamp_px + 8'd1;
        sel[0]   = bufPrev_q;
        sel[1]   = bufCur_q;
        sel[2]   = bufNext_q;
    end

    for (genvar g = 0; g < RING_LINES; g++) begin : g_ring
        gba_line_ram #(.DEPTH(LINE_PX)) u_line_ram (
            .clk    (pxlClk),
            .we     (we && (wbuf == 2'(g))),
            .waddr  (waddr),
            .wdata  (wdata),
            .raddr0 (col[0]),
            .raddr1 (col[1]),
            .raddr2 (col[2]),
            .rdata0 (rd[g][0]),
            .rdata1 (rd[g][1]),
            .rdata2 (rd[g][2])
        );
    end

    // A same-cycle write to a sampled location is forwarded so the window never shows stale data.
    always_comb begin
        for (int l = 0; l < 3; l++) begin
            for (int k = 0; k < 3; k++) begin
                nb_d[l][k] = rd[sel[l]][k];
                if (we && wbuf == sel[l] && waddr == col[k]) begin
                    nb_d[l][k] = wdata;
                end
            end
        end
    end

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            newFrame_prev_q <= 1'b0;
            wPxl_q          <= 8'd0;
            wLine_q         <= 8'd0;
            linesDone_q     <= 8'd0;
            rLine_q         <= 8'd0;
            bufPrev_q       <= 2'd0;
            bufCur_q        <= 2'd0;
            bufNext_q       <= 2'd0;
            sameLine_q      <= 1'b1;
            newFrameOut_q   <= 1'b0;
            overrun_q       <= 1'b0;
            for (int l = 0; l < 3; l++) begin
                for (int k = 0; k < 3; k++) begin
                    nb_q[l][k] <= '0;
                end
            end
        end else begin
            newFrame_prev_q <= bus.newFrameIn;
            wPxl_q          <= wPxl_d;
            wLine_q         <= wLine_d;
            linesDone_q     <= linesDone_d;
            rLine_q         <= rLine_d;
            bufPrev_q       <= bufPrev_d;
            bufCur_q        <= bufCur_d;
            bufNext_q       <= bufNext_d;
            sameLine_q      <= same_now;
            newFrameOut_q   <= resync;
            overrun_q       <= overrun_d;
            for (int l = 0; l < 3; l++) begin
                for (int k = 0; k < 3; k++) begin
                    nb_q[l][k] <= nb_d[l][k];
                end
            end
        end
    end

    assign bus.sameLine    = sameLine_q;
    assign bus.newFrameOut = newFrameOut_q;
    assign bus.overrun     = overrun_q;

    assign {bus.prevLinePrevPxlRedOut, bus.prevLinePrevPxlGreenOut, bus.prevLinePrevPxlBlueOut} = nb_q[0][0];
    assign {bus.prevLineCurPxlRedOut,  bus.prevLineCurPxlGreenOut,  bus.prevLineCurPxlBlueOut}  = nb_q[0][1];
    assign {bus.prevLineNextPxlRedOut, bus.prevLineNextPxlGreenOut, bus.prevLineNextPxlBlueOut} = nb_q[0][2];
    assign {bus.curLinePrevPxlRedOut,  bus.curLinePrevPxlGreenOut,  bus.curLinePrevPxlBlueOut}  = nb_q[1][0];
    assign {bus.curLineCurPxlRedOut,   bus.curLineCurPxlGreenOut,   bus.curLineCurPxlBlueOut}   = nb_q[1][1];
    assign {bus.curLineNextPxlRedOut,  bus.curLineNextPxlGreenOut,  bus.curLineNextPxlBlueOut}  = nb_q[1][2];
    assign {bus.nextLinePrevPxlRedOut, bus.nextLinePrevPxlGreenOut, bus.nextLinePrevPxlBlueOut} = nb_q[2][0];
    assign {bus.nextLineCurPxlRedOut,  bus.nextLineCurPxlGreenOut,  bus.nextLineCurPxlBlueOut}  = nb_q[2][1];
    assign {bus.nextLineNextPxlRedOut, bus.nextLineNextPxlGreenOut, bus.nextLineNextPxlBlueOut} = nb_q[2][2];

endmodule
